// File: rtl/dm_responder_pkg.sv
// Shared types for the MEM-stage data-memory responder: access types, FSM state, word type.
package dm_responder_pkg;

    typedef logic [31:0] vec32_t;

    typedef enum logic [2:0] {
        RD_NONE   = 3'd0,
        RD_BYTE   = 3'd1,
        RD_BYTE_U = 3'd2,
        RD_HALF   = 3'd3,
        RD_HALF_U = 3'd4,
        RD_WORD   = 3'd5
    } dm_read_type_e;

    typedef enum logic [1:0] {
        WR_NONE = 2'd0,
        WR_BYTE = 2'd1,
        WR_HALF = 2'd2,
        WR_WORD = 2'd3
    } dm_write_type_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dm_resp_state_e;

endpackage

// File: rtl/dm_lane_unit.sv
// Byte-lane merge for stores, lane select plus sign/zero extension for loads, and alignment check.
module dm_lane_unit
    import dm_responder_pkg::*;
(
    input  vec32_t         old_word,
    input  logic [1:0]     addr_lo,
    input  dm_read_type_e  rtype,
    input  dm_write_type_e wtype,
    input  vec32_t         wdata,
    output vec32_t         merged_word,
    output vec32_t         load_value,
    output logic           misalign
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    assign byte_val = old_word[{addr_lo, 3'b000} +: 8];
    assign half_val = addr_lo[1] ? old_word[31:16] : old_word[15:0];

    // A store takes priority over a load, so only the store type decides alignment then.
    // NOTE: every output gets a default first so no path through the case leaves a latch.
    always_comb begin
        merged_word = old_word;
        load_value  = '0;
        misalign    = 1'b0;
        if (wtype != WR_NONE) begin
            case (wtype)
                WR_BYTE: merged_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
                WR_HALF: begin
                    if (addr_lo[0]) misalign = 1'b1;
                    else            merged_word[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
                end
                WR_WORD: begin
                    if (addr_lo != 2'b00) misalign = 1'b1;
                    else                  merged_word = wdata;
                end
                default: ;
            endcase
            if (misalign) merged_word = old_word;
        end else begin
            case (rtype)
                RD_BYTE:   load_value = {{24{byte_val[7]}}, byte_val};
                RD_BYTE_U: load_value = {24'h0, byte_val};
                RD_HALF, RD_HALF_U: begin
                    if (addr_lo[0])          misalign   = 1'b1;
                    else if (rtype == RD_HALF) load_value = {{16{half_val[15]}}, half_val};
                    else                     load_value = {16'h0, half_val};
                end
                RD_WORD: begin
                    if (addr_lo != 2'b00) misalign   = 1'b1;
                    else                  load_value = old_word;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/dm_responder.sv
// Multi-cycle data-memory responder: one request at a time, LATENCY wait states, held response.
// Optional store trace is enabled by defining DM_TRACE_EN (adds the result_file input).
module dm_responder
    import dm_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
`ifdef DM_TRACE_EN
    input  integer      result_file,
`endif
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_pc,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_rtype,
    input  logic [1:0]  req_wtype,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    vec32_t                mem [DEPTH];
    dm_resp_state_e        state;
    logic [3:0]            wait_cnt;
    logic [ADDR_WIDTH-1:0] lat_index;
    logic [1:0]            lat_lo;
    dm_read_type_e         lat_rtype;
    dm_write_type_e        lat_wtype;
    vec32_t                lat_wdata;

    vec32_t merged_word;
    vec32_t load_value;
    logic   misalign;
    logic   commit;
    logic   store_commit;

    dm_lane_unit u_lane (
        .old_word    (mem[lat_index]),
        .addr_lo     (lat_lo),
        .rtype       (lat_rtype),
        .wtype       (lat_wtype),
        .wdata       (lat_wdata),
        .merged_word (merged_word),
        .load_value  (load_value),
        .misalign    (misalign)
    );

    // The last WAIT cycle is the commit point: the store lands and the response registers load.
    assign commit       = (state == WAIT) && (wait_cnt == 4'd0);
    assign store_commit = commit && (lat_wtype != WR_NONE) && !misalign;

    // WAIT always lasts LATENCY+1 cycles so resp_valid rises after edge accept+1+LATENCY.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            wait_cnt   <= '0;
            lat_index  <= '0;
            lat_lo     <= '0;
            lat_rtype  <= RD_NONE;
            lat_wtype  <= WR_NONE;
            lat_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_index <= req_addr[ADDR_WIDTH+1:2];
                        lat_lo    <= req_addr[1:0];
                        lat_rtype <= dm_read_type_e'(req_rtype);
                        lat_wtype <= dm_write_type_e'(req_wtype);
                        lat_wdata <= req_wdata;
                        wait_cnt  <= 4'(LATENCY);
                        req_ready <= 1'b0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        resp_valid <= 1'b1;
                        resp_rdata <= load_value;
                        resp_err   <= misalign;
                        state      <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_rdata <= '0;
                        resp_err   <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: the array is cleared by reset on purpose, so it builds as flops, not a RAM macro.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (store_commit) begin
            mem[lat_index] <= merged_word;
        end
    end

`ifdef DM_TRACE_EN
    vec32_t lat_pc;
    vec32_t lat_word_addr;

    always_ff @(posedge clock) begin
        if (reset) begin
            lat_pc        <= '0;
            lat_word_addr <= '0;
        end else if (state == IDLE && req_valid) begin
            lat_pc        <= req_pc;
            lat_word_addr <= {req_addr[31:2], 2'b00};
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && store_commit && lat_pc != '0) begin
            $display("@%08h: *%08h <= %08h", lat_pc, lat_word_addr, merged_word);
        end
    end
`else
    logic unused_req_bits;
    assign unused_req_bits = ^{req_pc, req_addr[31:ADDR_WIDTH+2]};
`endif

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench: table of load/store vectors on a LATENCY=2 responder plus hold, reset and LATENCY=0 sequences.
module tb_dm_responder;
    import dm_responder_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [31:0] req_pc, req_addr, req_wdata;
    logic [2:0]  req_rtype;
    logic [1:0]  req_wtype;
    logic        resp_ready;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        req_ready0, resp_valid0, resp_err0;
    logic [31:0] resp_rdata0;
    integer      trace_fd = 32'h8000_0001;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    dm_responder #(.ADDR_WIDTH(10), .LATENCY(2)) dut (
`ifdef DM_TRACE_EN
        .result_file (trace_fd),
`endif
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_pc(req_pc), .req_addr(req_addr), .req_rtype(req_rtype), .req_wtype(req_wtype),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    // Zero-latency, 16-word instance sharing the request inputs.
    dm_responder #(.ADDR_WIDTH(4), .LATENCY(0)) dut0 (
`ifdef DM_TRACE_EN
        .result_file (trace_fd),
`endif
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready0),
        .req_pc(req_pc), .req_addr(req_addr), .req_rtype(req_rtype), .req_wtype(req_wtype),
        .req_wdata(req_wdata), .resp_valid(resp_valid0), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata0), .resp_err(resp_err0)
    );

    typedef struct {
        dm_read_type_e  rtype;
        dm_write_type_e wtype;
        logic [31:0]    addr;
        logic [31:0]    wdata;
        logic [31:0]    exp_rdata;
        logic           exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %0s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    task automatic add(input dm_read_type_e rt, input dm_write_type_e wt, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] er, input logic ee);
        vec_t v;
        v.rtype = rt; v.wtype = wt; v.addr = a; v.wdata = wd; v.exp_rdata = er; v.exp_err = ee;
        vecs.push_back(v);
    endtask

    task automatic drive_req(input dm_read_type_e rt, input dm_write_type_e wt,
                             input logic [31:0] a, input logic [31:0] wd);
        req_rtype = rt;
        req_wtype = wt;
        req_addr  = a;
        req_wdata = wd;
        req_pc    = 32'h0000_1000 + a;
        req_valid = 1'b1;
    endtask

    task automatic wait_resp(output int lat);
        lat = 0;
        while (!resp_valid && lat < 40) begin
            @(posedge clock);
            @(negedge clock);
            lat++;
        end
    endtask

    // One full handshake; returns cycles from the accept edge to resp_valid.
    task automatic transact(input string name, input dm_read_type_e rt, input dm_write_type_e wt,
                            input logic [31:0] a, input logic [31:0] wd,
                            output int lat, output logic [31:0] rd, output logic err);
        @(negedge clock);
        check({name, " req_ready"}, 32'(req_ready), 32'd1);
        drive_req(rt, wt, a, wd);
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        wait_resp(lat);
        rd  = resp_rdata;
        err = resp_err;
        resp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        resp_ready = 1'b0;
        check({name, " resp_valid drop"}, 32'(resp_valid), 32'd0);
    endtask

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        err;

        reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
        req_pc = '0; req_addr = '0; req_rtype = '0; req_wtype = '0; req_wdata = '0;

        add(RD_NONE,   WR_WORD, 32'h10,       32'hDEADBEEF, 32'h0,        1'b0);
        add(RD_WORD,   WR_NONE, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0);
        add(RD_NONE,   WR_WORD, 32'h10,       32'h0,        32'h0,        1'b0);
        add(RD_NONE,   WR_BYTE, 32'h13,       32'h12345680, 32'h0,        1'b0);
        add(RD_BYTE,   WR_NONE, 32'h13,       32'h0,        32'hFFFFFF80, 1'b0);
        add(RD_BYTE_U, WR_NONE, 32'h13,       32'h0,        32'h00000080, 1'b0);
        add(RD_WORD,   WR_NONE, 32'h10,       32'h0,        32'h80000000, 1'b0);
        add(RD_HALF,   WR_NONE, 32'h11,       32'h0,        32'h0,        1'b1);
        add(RD_NONE,   WR_WORD, 32'h12,       32'hCAFEF00D, 32'h0,        1'b1);
        add(RD_WORD,   WR_NONE, 32'h10,       32'h0,        32'h80000000, 1'b0);
        add(RD_NONE,   WR_HALF, 32'h16,       32'hAAAA8001, 32'h0,        1'b0);
        add(RD_HALF,   WR_NONE, 32'h16,       32'h0,        32'hFFFF8001, 1'b0);
        add(RD_HALF_U, WR_NONE, 32'h16,       32'h0,        32'h00008001, 1'b0);
        add(RD_HALF,   WR_NONE, 32'h14,       32'h0,        32'h0,        1'b0);
        add(RD_NONE,   WR_BYTE, 32'h15,       32'h0000007F, 32'h0,        1'b0);
        add(RD_BYTE,   WR_NONE, 32'h15,       32'h0,        32'h0000007F, 1'b0);
        add(RD_WORD,   WR_BYTE, 32'h14,       32'h00000011, 32'h0,        1'b0);
        add(RD_WORD,   WR_NONE, 32'h14,       32'h0,        32'h80017F11, 1'b0);
        add(RD_NONE,   WR_NONE, 32'h14,       32'hFFFFFFFF, 32'h0,        1'b0);
        add(RD_WORD,   WR_NONE, 32'h1010,     32'h0,        32'h80000000, 1'b0);
        add(RD_NONE,   WR_WORD, 32'hFFFF1018, 32'h01020304, 32'h0,        1'b0);
        add(RD_WORD,   WR_NONE, 32'h18,       32'h0,        32'h01020304, 1'b0);
        add(RD_BYTE_U, WR_NONE, 32'h1A,       32'h0,        32'h00000002, 1'b0);
        add(RD_WORD,   WR_NONE, 32'h1B,       32'h0,        32'h0,        1'b1);
        add(RD_NONE,   WR_HALF, 32'h19,       32'h0000FFFF, 32'h0,        1'b1);
        add(RD_WORD,   WR_NONE, 32'h18,       32'h0,        32'h01020304, 1'b0);
        add(RD_BYTE,   WR_NONE, 32'h1B,       32'h0,        32'h00000001, 1'b0);
        add(RD_HALF_U, WR_WORD, 32'h16,       32'hFFFFFFFF, 32'h0,        1'b1);
        add(RD_WORD,   WR_NONE, 32'h14,       32'h0,        32'h80017F11, 1'b0);

        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check("reset req_ready",  32'(req_ready),  32'd1);
        check("reset resp_valid", 32'(resp_valid), 32'd0);
        check("reset resp_rdata", resp_rdata,      32'd0);
        check("reset resp_err",   32'(resp_err),   32'd0);

        foreach (vecs[i]) begin
            transact($sformatf("v%0d", i), vecs[i].rtype, vecs[i].wtype, vecs[i].addr,
                     vecs[i].wdata, lat, rd, err);
            check($sformatf("v%0d latency", i), 32'(lat), 32'd3);
            check($sformatf("v%0d rdata", i),   rd,       vecs[i].exp_rdata);
            check($sformatf("v%0d err", i),     32'(err), 32'(vecs[i].exp_err));
        end

        // Response held under back-pressure; a competing store must be ignored.
        @(negedge clock);
        drive_req(RD_WORD, WR_NONE, 32'h10, 32'h0);
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        wait_resp(lat);
        check("hold latency", 32'(lat), 32'd3);
        drive_req(RD_NONE, WR_WORD, 32'h10, 32'hFFFFFFFF);
        for (int c = 0; c < 5; c++) begin
            @(posedge clock);
            @(negedge clock);
            check($sformatf("hold c%0d resp_valid", c), 32'(resp_valid), 32'd1);
            check($sformatf("hold c%0d rdata", c),      resp_rdata,      32'h80000000);
            check($sformatf("hold c%0d req_ready", c),  32'(req_ready),  32'd0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        resp_ready = 1'b0;
        transact("after hold", RD_WORD, WR_NONE, 32'h10, 32'h0, lat, rd, err);
        check("after hold rdata", rd, 32'h80000000);

        // Reset while a store is still waiting: store is lost, array cleared.
        @(negedge clock);
        drive_req(RD_NONE, WR_WORD, 32'h20, 32'h00001234);
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        reset     = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check("midreset req_ready",  32'(req_ready),  32'd1);
        check("midreset resp_valid", 32'(resp_valid), 32'd0);
        repeat (4) @(posedge clock);
        @(negedge clock);
        check("midreset no resp", 32'(resp_valid), 32'd0);
        transact("load 0x20", RD_WORD, WR_NONE, 32'h20, 32'h0, lat, rd, err);
        check("load 0x20 rdata", rd, 32'h0);
        transact("load 0x10 cleared", RD_WORD, WR_NONE, 32'h10, 32'h0, lat, rd, err);
        check("load 0x10 cleared rdata", rd, 32'h0);

        // LATENCY=0 instance: response after edge 1, and address aliasing on a 16-word array.
        @(negedge clock);
        drive_req(RD_NONE, WR_WORD, 32'h4, 32'h000055AA);
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        check("lat0 early resp_valid", 32'(resp_valid0), 32'd0);
        @(posedge clock);
        @(negedge clock);
        check("lat0 resp_valid",      32'(resp_valid0), 32'd1);
        check("lat0 resp_err",        32'(resp_err0),   32'd0);
        check("lat2 not yet valid",   32'(resp_valid),  32'd0);
        resp_ready = 1'b1;
        repeat (4) @(posedge clock);
        @(negedge clock);
        resp_ready = 1'b0;
        check("lat0 idle req_ready", 32'(req_ready0), 32'd1);
        check("lat2 idle req_ready", 32'(req_ready),  32'd1);
        drive_req(RD_WORD, WR_NONE, 32'h44, 32'h0);
        resp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("lat0 alias resp_valid", 32'(resp_valid0), 32'd1);
        check("lat0 alias rdata",      resp_rdata0,      32'h000055AA);
        repeat (4) @(posedge clock);
        @(negedge clock);
        resp_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
